// File: rtl/rob_pkg.sv
// Shared types and default sizing for the N-way reorder buffer.
package rob_pkg;

  localparam int unsigned RobSizeDef  = 32;
  localparam int unsigned RobDpWidth  = 2;
  localparam int unsigned RobCdbWidth = 2;
  localparam int unsigned RobRtWidth  = 2;
  localparam int unsigned RobXlen     = 32;
  localparam int unsigned RobRegW     = 5;

  // One ROB slot. Field widths follow the package defaults for XLEN/REG_W.
  typedef struct packed {
    logic                 valid;
    logic                 cp;       // result written back
    logic                 ep;       // mispredict/exception pending
    logic [RobRegW-1:0]   reg_idx;
    logic [RobXlen-1:0]   pc;
    logic [RobXlen-1:0]   npc;
    logic [RobXlen-1:0]   value;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Picks the contiguous run of retirable entries at the head of the ROB.
module rob_retire_select #(
  parameter int unsigned RT_WIDTH = 2,
  parameter int unsigned OCC_W    = 6,
  parameter int unsigned CNT_W    = 2
) (
  input  logic [RT_WIDTH-1:0] win_valid,
  input  logic [RT_WIDTH-1:0] win_cp,
  input  logic [RT_WIDTH-1:0] win_ep,
  input  logic [OCC_W-1:0]    occupancy,
  input  logic                stall,
  output logic [RT_WIDTH-1:0] rt_valid,
  output logic [RT_WIDTH-1:0] rt_mispredict,
  output logic [CNT_W-1:0]    rt_count
);

  logic go;

  // Walk head window in order; stop at first incomplete slot or after a mispredict.
  always_comb begin
    go            = !stall;
    rt_valid      = '0;
    rt_mispredict = '0;
    rt_count      = '0;
    for (int k = 0; k < RT_WIDTH; k++) begin
      if (go && (OCC_W'(k) < occupancy) && win_valid[k] && win_cp[k]) begin
        rt_valid[k] = 1'b1;
        rt_count    = rt_count + 1'b1;
        if (win_ep[k]) begin
          rt_mispredict[k] = 1'b1;
          go               = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_nway.sv
// N-way reorder buffer: in-order allocate, out-of-order complete, in-order retire.
module rob_nway
  import rob_pkg::*;
#(
  parameter int unsigned ROB_SIZE  = RobSizeDef,
  parameter int unsigned DP_WIDTH  = RobDpWidth,
  parameter int unsigned CDB_WIDTH = RobCdbWidth,
  parameter int unsigned RT_WIDTH  = RobRtWidth,
  parameter int unsigned XLEN      = RobXlen,
  parameter int unsigned REG_W     = RobRegW,
  parameter int unsigned TAG_W     = $clog2(ROB_SIZE)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            squash,
  input  logic [DP_WIDTH-1:0]             dp_valid,
  input  logic [DP_WIDTH*REG_W-1:0]       dp_dest_reg,
  input  logic [DP_WIDTH*XLEN-1:0]        dp_pc,
  output logic [DP_WIDTH*TAG_W-1:0]       dp_tag,
  output logic [TAG_W:0]                  dp_free_slots,
  input  logic [CDB_WIDTH-1:0]            cdb_valid,
  input  logic [CDB_WIDTH*TAG_W-1:0]      cdb_tag,
  input  logic [CDB_WIDTH*XLEN-1:0]       cdb_value,
  input  logic [CDB_WIDTH-1:0]            cdb_take_branch,
  input  logic [CDB_WIDTH*XLEN-1:0]       cdb_npc,
  input  logic [2*DP_WIDTH*TAG_W-1:0]     rd_tag,
  output logic [2*DP_WIDTH-1:0]           rd_ready,
  output logic [2*DP_WIDTH*XLEN-1:0]      rd_value,
  input  logic                            retire_stall,
  output logic [RT_WIDTH-1:0]             rt_valid,
  output logic [RT_WIDTH*REG_W-1:0]       rt_dest_reg,
  output logic [RT_WIDTH*XLEN-1:0]        rt_value,
  output logic [RT_WIDTH*XLEN-1:0]        rt_pc,
  output logic [RT_WIDTH*XLEN-1:0]        rt_npc,
  output logic [RT_WIDTH-1:0]             rt_mispredict
);

  localparam int unsigned PTR_W    = TAG_W + 1;
  localparam int unsigned CNT_W    = $clog2(RT_WIDTH + 1);
  localparam int unsigned RD_LANES = 2 * DP_WIDTH;

  rob_entry_t entries_q [ROB_SIZE];
  rob_entry_t entries_d [ROB_SIZE];
  rob_entry_t win_entry [RT_WIDTH];

  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]    occupancy, dp_count;
  logic [TAG_W-1:0]    head_idx, tail_idx;
  logic [ROB_SIZE-1:0] alloc_mask, live_mask;
  logic [RT_WIDTH-1:0] win_valid, win_cp, win_ep;
  logic [CNT_W-1:0]    rt_count;
  logic                flush;

  assign occupancy     = tail_q - head_q;
  assign dp_free_slots = PTR_W'(ROB_SIZE) - occupancy;
  assign head_idx      = head_q[TAG_W-1:0];
  assign tail_idx      = tail_q[TAG_W-1:0];
  assign flush         = squash | (|rt_mispredict);

  // Tags handed to dispatch lanes and the slots they claim this cycle.
  always_comb begin
    dp_count   = '0;
    alloc_mask = '0;
    dp_tag     = '0;
    for (int i = 0; i < DP_WIDTH; i++) begin
      dp_tag[i*TAG_W +: TAG_W] = tail_idx + TAG_W'(i);
      if (dp_valid[i]) begin
        dp_count = dp_count + 1'b1;
        alloc_mask[tail_idx + TAG_W'(i)] = 1'b1;
      end
    end
  end

  // A CDB write is accepted only by a live slot (already valid or allocated now).
  always_comb begin
    live_mask = '0;
    for (int s = 0; s < ROB_SIZE; s++) begin
      live_mask[s] = entries_q[s].valid | alloc_mask[s];
    end
  end

  // Head window and retire-lane field outputs.
  always_comb begin
    rt_dest_reg = '0;
    rt_value    = '0;
    rt_pc       = '0;
    rt_npc      = '0;
    for (int k = 0; k < RT_WIDTH; k++) begin
      win_entry[k] = entries_q[head_idx + TAG_W'(k)];
      win_valid[k] = win_entry[k].valid;
      win_cp[k]    = win_entry[k].cp;
      win_ep[k]    = win_entry[k].ep;
      rt_dest_reg[k*REG_W +: REG_W] = win_entry[k].reg_idx;
      rt_value[k*XLEN +: XLEN]      = win_entry[k].value;
      rt_pc[k*XLEN +: XLEN]         = win_entry[k].pc;
      rt_npc[k*XLEN +: XLEN]        = win_entry[k].npc;
    end
  end

  rob_retire_select #(
    .RT_WIDTH (RT_WIDTH),
    .OCC_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_retire_select (
    .win_valid     (win_valid),
    .win_cp        (win_cp),
    .win_ep        (win_ep),
    .occupancy     (occupancy),
    .stall         (retire_stall | ~enable),
    .rt_valid      (rt_valid),
    .rt_mispredict (rt_mispredict),
    .rt_count      (rt_count)
  );

  // Operand lookup; CDB forwarding overrides, lowest lane applied last so it wins.
  always_comb begin
    rd_ready = '0;
    rd_value = '0;
    for (int j = 0; j < RD_LANES; j++) begin
      if (entries_q[rd_tag[j*TAG_W +: TAG_W]].valid && entries_q[rd_tag[j*TAG_W +: TAG_W]].cp) begin
        rd_ready[j]              = 1'b1;
        rd_value[j*XLEN +: XLEN] = entries_q[rd_tag[j*TAG_W +: TAG_W]].value;
      end
      for (int l = CDB_WIDTH - 1; l >= 0; l--) begin
        if (cdb_valid[l] && (cdb_tag[l*TAG_W +: TAG_W] == rd_tag[j*TAG_W +: TAG_W]) &&
            live_mask[cdb_tag[l*TAG_W +: TAG_W]]) begin
          rd_ready[j]              = 1'b1;
          rd_value[j*XLEN +: XLEN] = cdb_value[l*XLEN +: XLEN];
        end
      end
    end
  end

  // Next state: dispatch, then completion (so same-cycle completion sticks), then retire.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush) begin
      for (int s = 0; s < ROB_SIZE; s++) begin
        entries_d[s] = '0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int i = 0; i < DP_WIDTH; i++) begin
        if (dp_valid[i]) begin
          entries_d[tail_idx + TAG_W'(i)].valid   = 1'b1;
          entries_d[tail_idx + TAG_W'(i)].cp      = 1'b0;
          entries_d[tail_idx + TAG_W'(i)].ep      = 1'b0;
          entries_d[tail_idx + TAG_W'(i)].reg_idx = dp_dest_reg[i*REG_W +: REG_W];
          entries_d[tail_idx + TAG_W'(i)].pc      = dp_pc[i*XLEN +: XLEN];
          entries_d[tail_idx + TAG_W'(i)].npc     = '0;
          entries_d[tail_idx + TAG_W'(i)].value   = '0;
        end
      end
      for (int l = CDB_WIDTH - 1; l >= 0; l--) begin
        if (cdb_valid[l] && live_mask[cdb_tag[l*TAG_W +: TAG_W]]) begin
          entries_d[cdb_tag[l*TAG_W +: TAG_W]].cp    = 1'b1;
          entries_d[cdb_tag[l*TAG_W +: TAG_W]].ep    = cdb_take_branch[l];
          entries_d[cdb_tag[l*TAG_W +: TAG_W]].value = cdb_value[l*XLEN +: XLEN];
          entries_d[cdb_tag[l*TAG_W +: TAG_W]].npc   = cdb_npc[l*XLEN +: XLEN];
        end
      end
      for (int k = 0; k < RT_WIDTH; k++) begin
        if (rt_valid[k]) begin
          entries_d[head_idx + TAG_W'(k)].valid = 1'b0;
        end
      end
      head_d = head_q + PTR_W'(rt_count);
      tail_d = tail_q + dp_count;
    end
  end

  // State registers; enable=0 freezes everything including flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q <= '0;
      tail_q <= '0;
      for (int s = 0; s < ROB_SIZE; s++) begin
        entries_q[s] <= '0;
      end
    end else if (enable) begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

  // Dispatch must never ask for more slots than are free.
  assert property (@(posedge clock) disable iff (!reset) enable |-> (dp_count <= dp_free_slots));

endmodule

// File: tb/tb_rob_nway.sv
// Directed self-checking bench for rob_nway with default parameters.
module tb_rob_nway;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b1;
  logic         squash = 1'b0;
  logic [1:0]   dp_valid;
  logic [9:0]   dp_dest_reg;
  logic [63:0]  dp_pc;
  logic [9:0]   dp_tag;
  logic [5:0]   dp_free_slots;
  logic [1:0]   cdb_valid;
  logic [9:0]   cdb_tag;
  logic [63:0]  cdb_value;
  logic [1:0]   cdb_take_branch;
  logic [63:0]  cdb_npc;
  logic [19:0]  rd_tag;
  logic [3:0]   rd_ready;
  logic [127:0] rd_value;
  logic         retire_stall = 1'b0;
  logic [1:0]   rt_valid;
  logic [9:0]   rt_dest_reg;
  logic [63:0]  rt_value;
  logic [63:0]  rt_pc;
  logic [63:0]  rt_npc;
  logic [1:0]   rt_mispredict;

  int n_checks = 0;
  int n_pass   = 0;
  int next_tag = 0;

  rob_nway dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .squash          (squash),
    .dp_valid        (dp_valid),
    .dp_dest_reg     (dp_dest_reg),
    .dp_pc           (dp_pc),
    .dp_tag          (dp_tag),
    .dp_free_slots   (dp_free_slots),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_value       (cdb_value),
    .cdb_take_branch (cdb_take_branch),
    .cdb_npc         (cdb_npc),
    .rd_tag          (rd_tag),
    .rd_ready        (rd_ready),
    .rd_value        (rd_value),
    .retire_stall    (retire_stall),
    .rt_valid        (rt_valid),
    .rt_dest_reg     (rt_dest_reg),
    .rt_value        (rt_value),
    .rt_pc           (rt_pc),
    .rt_npc          (rt_npc),
    .rt_mispredict   (rt_mispredict)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_dp();
    dp_valid    = '0;
    dp_dest_reg = '0;
    dp_pc       = '0;
  endtask

  task automatic clear_cdb();
    cdb_valid       = '0;
    cdb_tag         = '0;
    cdb_value       = '0;
    cdb_take_branch = '0;
    cdb_npc         = '0;
  endtask

  // Dispatch n entries; dest reg = tag, pc = 0x1000 + 4*tag.
  task automatic drive_dispatch(input int n);
    clear_dp();
    for (int i = 0; i < n; i++) begin
      dp_valid[i]            = 1'b1;
      dp_dest_reg[i*5 +: 5]  = 5'((next_tag + i) % 32);
      dp_pc[i*32 +: 32]      = 32'h1000 + 32'(4 * ((next_tag + i) % 32));
    end
    next_tag += n;
  endtask

  task automatic drive_cdb(input int lane, input int tag, input logic [31:0] val,
                           input logic tb, input logic [31:0] npc);
    cdb_valid[lane]          = 1'b1;
    cdb_tag[lane*5 +: 5]     = 5'(tag);
    cdb_value[lane*32 +: 32] = val;
    cdb_take_branch[lane]    = tb;
    cdb_npc[lane*32 +: 32]   = npc;
  endtask

  initial begin
    clear_dp();
    clear_cdb();
    rd_tag = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check_eq("rst_free", dp_free_slots, 32);
    check_eq("rst_rt_valid", rt_valid, 0);
    check_eq("rst_rd_ready", rd_ready, 0);

    // 1: five entries, one complete, then asynchronous reset
    retire_stall = 1'b1;
    drive_dispatch(2); step();
    drive_dispatch(2); step();
    drive_dispatch(1); step();
    clear_dp();
    drive_cdb(0, 0, 32'h55, 1'b0, 32'h0); step();
    clear_cdb();
    retire_stall = 1'b0;
    #1;
    check_eq("t1_free5", dp_free_slots, 27);
    check_eq("t1_rd_ready", rd_ready, 4'hf);
    check_eq("t1_rd_value", rd_value[31:0], 32'h55);
    check_eq("t1_rt_valid", rt_valid, 2'b01);
    reset = 1'b0;
    #1;
    check_eq("t1_async_free", dp_free_slots, 32);
    check_eq("t1_async_rd_ready", rd_ready, 0);
    check_eq("t1_async_rt_valid", rt_valid, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    next_tag = 0;
    #1;
    check_eq("t1_post_free", dp_free_slots, 32);

    // 2: fill at two per cycle
    for (int c = 0; c < 16; c++) begin
      drive_dispatch(2);
      #1;
      check_eq("t2_dp_tag", dp_tag, {5'(2 * c + 1), 5'(2 * c)});
      check_eq("t2_free", dp_free_slots, 32 - 2 * c);
      step();
    end
    clear_dp();
    #1;
    check_eq("t2_full_free", dp_free_slots, 0);
    check_eq("t2_tail_wrap", dut.tail_q, 6'd32);
    check_eq("t2_wrap_tag", dp_tag, {5'd1, 5'd0});

    // 3: complete head pair, zero-latency retire
    drive_cdb(0, 0, 32'h10, 1'b0, 32'h0);
    drive_cdb(1, 1, 32'h11, 1'b0, 32'h0);
    step();
    clear_cdb();
    #1;
    check_eq("t3_rt_valid", rt_valid, 2'b11);
    check_eq("t3_rt_value", rt_value, {32'h11, 32'h10});
    check_eq("t3_rt_dest", rt_dest_reg, {5'd1, 5'd0});
    check_eq("t3_rt_pc", rt_pc, {32'h1004, 32'h1000});
    check_eq("t3_rt_misp", rt_mispredict, 0);
    check_eq("t3_free_n1", dp_free_slots, 0);
    step();
    check_eq("t3_free_n2", dp_free_slots, 2);
    check_eq("t3_rt_valid_n2", rt_valid, 0);

    // 4: same-cycle dispatch + CDB on tag 30, duplicate CDB tag
    squash = 1'b1; step(); squash = 1'b0;
    next_tag = 0;
    #1;
    check_eq("t4_squash_free", dp_free_slots, 32);
    for (int c = 0; c < 15; c++) begin
      drive_dispatch(2); step();
    end
    clear_dp();
    #1;
    check_eq("t4_free30", dp_free_slots, 2);
    drive_dispatch(1);
    drive_cdb(0, 30, 32'hAB, 1'b0, 32'h0);
    drive_cdb(1, 30, 32'hCD, 1'b0, 32'h0);
    rd_tag = {5'd0, 5'd0, 5'd29, 5'd30};
    #1;
    check_eq("t4_dp_tag30", dp_tag[4:0], 30);
    check_eq("t4_fwd_ready", rd_ready[1:0], 2'b01);
    check_eq("t4_fwd_value", rd_value[31:0], 32'hAB);
    step();
    clear_dp();
    clear_cdb();
    #1;
    check_eq("t4_rd_ready", rd_ready[1:0], 2'b01);
    check_eq("t4_rd_value", rd_value[31:0], 32'hAB);
    check_eq("t4_rd_value_nr", rd_value[63:32], 0);
    check_eq("t4_free", dp_free_slots, 1);

    // 5: mispredict on tag 4 retires with 3, then self-flush
    squash = 1'b1; step(); squash = 1'b0;
    next_tag = 0;
    retire_stall = 1'b1;
    drive_dispatch(2); step();
    drive_dispatch(2); step();
    drive_dispatch(2); step();
    drive_dispatch(1); step();
    clear_dp();
    drive_cdb(0, 0, 32'h20, 1'b0, 32'h0);
    drive_cdb(1, 1, 32'h21, 1'b0, 32'h0);
    step();
    clear_cdb();
    drive_cdb(0, 2, 32'h22, 1'b0, 32'h0);
    step();
    clear_cdb();
    retire_stall = 1'b0;
    #1;
    check_eq("t5_rt01", rt_valid, 2'b11);
    step();
    check_eq("t5_rt2", rt_valid, 2'b01);
    check_eq("t5_rt2_dest", rt_dest_reg[4:0], 2);
    step();
    drive_cdb(0, 3, 32'h33, 1'b0, 32'h0);
    drive_cdb(1, 4, 32'h44, 1'b1, 32'h100);
    #1;
    check_eq("t5_rt_wait", rt_valid, 0);
    step();
    clear_cdb();
    #1;
    check_eq("t5_rt34", rt_valid, 2'b11);
    check_eq("t5_misp", rt_mispredict, 2'b10);
    check_eq("t5_npc", rt_npc[63:32], 32'h100);
    check_eq("t5_value3", rt_value[31:0], 32'h33);
    check_eq("t5_free", dp_free_slots, 28);
    step();
    rd_tag = {5'd0, 5'd0, 5'd0, 5'd6};
    #1;
    check_eq("t5_flush_free", dp_free_slots, 32);
    check_eq("t5_flush_rt", rt_valid, 0);
    check_eq("t5_head", dut.head_q, 0);
    check_eq("t5_tail", dut.tail_q, 0);
    check_eq("t5_flush_rd", rd_ready[0], 1'b0);

    // 6: CDB to unallocated slot ignored; squash with enable=0 held
    next_tag = 0;
    drive_dispatch(2); step();
    clear_dp();
    drive_cdb(0, 20, 32'h77, 1'b0, 32'h0);
    rd_tag = {5'd0, 5'd0, 5'd0, 5'd20};
    #1;
    check_eq("t6_unalloc_fwd", rd_ready[0], 1'b0);
    step();
    clear_cdb();
    #1;
    check_eq("t6_unalloc_rd", rd_ready[0], 1'b0);
    check_eq("t6_free", dp_free_slots, 30);
    check_eq("t6_rt_valid", rt_valid, 0);
    retire_stall = 1'b1;
    drive_cdb(0, 0, 32'h5A, 1'b0, 32'h0);
    step();
    clear_cdb();
    enable = 1'b0;
    squash = 1'b1;
    retire_stall = 1'b0;
    drive_dispatch(2);
    drive_cdb(0, 1, 32'h99, 1'b0, 32'h0);
    #1;
    check_eq("t6_disabled_rt", rt_valid, 0);
    step();
    enable = 1'b1;
    squash = 1'b0;
    retire_stall = 1'b1;
    clear_dp();
    clear_cdb();
    rd_tag = {5'd0, 5'd0, 5'd0, 5'd1};
    #1;
    check_eq("t6_held_free", dp_free_slots, 30);
    check_eq("t6_held_tail", dut.tail_q, 2);
    check_eq("t6_held_rd1", rd_ready[1:0], 2'b10);
    check_eq("t6_held_val0", rd_value[63:32], 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
